// File: rtl/param_frame_tx_pkg.sv
// Shared constants and types for the 6-byte parameter frame (tx and rx sides).
package param_frame_tx_pkg;
  localparam int          FRAME_LEN = 6;
  localparam logic [7:0]  FRAME_END = 8'hF7;
  localparam int          IDX_W     = 3;
  localparam int          HOLD_W    = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_e;
endpackage

// File: rtl/frame_byte_sel.sv
// Frame byte mux: picks byte idx out of the 40-bit hold, MSB first; the
// terminator occupies the last slot.
import param_frame_tx_pkg::*;

module frame_byte_sel (
  input  logic [HOLD_W-1:0] hold,
  input  logic [IDX_W-1:0]  idx,
  output logic [7:0]        data_o
);

  // Index 0 is b0[15:8], so the receiver's left shift lands it in [47:40].
  always_comb begin
    data_o = FRAME_END;
    case (idx)
      3'd0:    data_o = hold[39:32];
      3'd1:    data_o = hold[31:24];
      3'd2:    data_o = hold[23:16];
      3'd3:    data_o = hold[15:8];
      3'd4:    data_o = hold[7:0];
      default: data_o = FRAME_END;
    endcase
  end

endmodule

// File: rtl/param_frame_tx.sv
// Parameter frame transmitter: snapshots b0/b1/vr on start, sends the six
// frame bytes through the shared UART handshake, pulses eop or err at the end.
import param_frame_tx_pkg::*;

module param_frame_tx #(
  parameter int TIMEOUT = 200000,
  parameter int TO_W    = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic [7:0]  vr,
  input  logic        eo_Tx,
  output logic [7:0]  DATA_Tx,
  output logic        st_Tx,
  output logic        busy,
  output logic        eop,
  output logic        err
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                st_tx_q, st_tx_d;
  logic                busy_q, busy_d;
  logic                eop_q, eop_d;
  logic                err_q, err_d;

  // DATA_Tx is a pure mux of registered hold/idx, so it is stable for the
  // whole SEND/WAIT span of a byte and zero out of reset.
  frame_byte_sel u_sel (
    .hold   (hold_q),
    .idx    (idx_q),
    .data_o (DATA_Tx)
  );

  // Next-state and registered-output decode; pulses default low each cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    st_tx_d = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st) begin
          state_d = S_SNAP;
          busy_d  = 1'b1;
        end
      end
      S_SNAP: begin
        hold_d  = {b0, b1, vr};
        idx_d   = '0;
        state_d = S_SEND;
        st_tx_d = 1'b1;
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // eo_Tx takes priority over a timeout expiring in the same cycle.
        if (eo_Tx) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d = S_DONE;
            eop_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
            st_tx_d = 1'b1;
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE, S_ABORT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops a frame in flight silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      st_tx_q <= 1'b0;
      busy_q  <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      st_tx_q <= st_tx_d;
      busy_q  <= busy_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign st_Tx = st_tx_q;
  assign busy  = busy_q;
  assign eop   = eop_q;
  assign err   = err_q;

endmodule

// File: doc/param_frame_tx.md
# param_frame_tx

Transmit side of the 6-byte parameter frame that the robot receives from the host: controller gains b0, b1 and base speed vr, then terminator 0xF7. On a start pulse it snapshots the three values, serializes them byte-by-byte into the UART transmitter via the st_Tx/eo_Tx handshake, and pulses eop when done. Used as the parameter read-back path, so the host can confirm the gains actually latched, and as the stimulus source in loopback tests of the receive path. Shares the UART transmitter with the telemetry sender through an external arbiter.

## Interface
- TIMEOUT, 200000: max cycles to wait for eo_Tx after each st_Tx before aborting.
- TO_W, 18: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

- rst  in  1  asynchronous reset, active-low
- clk  in  1  system clock
- st  in  1  single-cycle start request
- b0  in  16  gain b0, sampled on accepted st
- b1  in  16  gain b1, sampled on accepted st
- vr  in  8  base speed, sampled on accepted st
- eo_Tx  in  1  single-cycle pulse from UART: current byte fully shifted out
- DATA_Tx  out  8  byte presented to UART
- st_Tx  out  1  single-cycle pulse: UART loads DATA_Tx
- busy  out  1  high from accepted st until eop/err cycle inclusive
- eop  out  1  single-cycle pulse: frame completed
- err  out  1  single-cycle pulse: frame aborted by timeout

## Operation
- Frame byte order, index 0..5: b0[15:8], b0[7:0], b1[15:8], b1[7:0], vr, 0xF7. This matches the receive left-shift register, so the first byte ends in bits [47:40].
- FSM states:
  - IDLE: busy=0. st=1 → SNAP.
  - SNAP: latch b0/b1/vr into a 40-bit hold; idx=0 → SEND.
  - SEND: DATA_Tx=byte[idx], st_Tx=1 for one cycle, clear timeout counter → WAIT.
  - WAIT: DATA_Tx held stable.
    - eo_Tx=1 and idx<5: idx+1 → SEND.
    - eo_Tx=1 and idx=5 → DONE.
    - Counter reaches TIMEOUT → ABORT.
  - DONE: eop=1 → IDLE.
  - ABORT: err=1 → IDLE.
- st in any state other than IDLE is ignored; no queuing.
- eo_Tx outside WAIT is ignored.
- Changes on b0/b1/vr after SNAP do not affect the frame in flight.
- If eo_Tx and timeout expiry occur in the same cycle, eo_Tx wins.
- Reset values: DATA_Tx=0, st_Tx=0, busy=0, eop=0, err=0, state IDLE, idx=0, hold=0.
- Reset mid-frame aborts immediately. No eop or err pulse is produced, and the UART is not notified.

## Timing
- st accepted at cycle t:
  - SNAP at t+1, busy=1 from t+1.
  - First st_Tx at t+2 with DATA_Tx=b0[15:8].
- eo_Tx at cycle n (idx<5) → next st_Tx at n+1 with the next byte.
- Last eo_Tx at n → eop=1 at n+1. busy falls at n+2.
  - A new st at n+2 is accepted.
- Timeout: err at st_Tx cycle + TIMEOUT + 1; busy falls the following cycle.
- Total frame latency: 2 + Σ(per-byte UART time + 1) cycles.

## Structure
- Shared package: FRAME_LEN=6 and FRAME_END=8'hF7. The receive-side flag_fin compare uses the same constants.
- Sub-module frame_byte_sel: combinational 40-bit hold + 3-bit idx → 8-bit byte, with index 5 returning FRAME_END. Everything else stays in one FSM module.

## Test plan
- Normal frame: b0=16'h1234, b1=16'hABCD, vr=8'h55, st=1, UART model returns eo_Tx 100 cycles after each st_Tx → bytes 12,34,AB,CD,55,F7 in order, six st_Tx pulses, one eop, no err.
- Snapshot and busy: change b0 to 16'hFFFF and pulse st during byte 2 → frame still carries 12,34; the second st produces no extra frame.
- Timeout: TIMEOUT=50, withhold eo_Tx after byte 3 → err exactly 51 cycles after that st_Tx; busy low next cycle; no eop.
- Reset mid-frame: assert rst during WAIT of byte 4 → all outputs 0 immediately. A fresh st after release sends a full 6-byte frame from byte 0.
- Back-to-back: st asserted in the cycle busy falls → second frame starts, first st_Tx 2 cycles later; eo_Tx coincident with timeout expiry → byte advances, no err.
- Loopback: feed DATA_Tx bytes into the receive shift/hold registers → recovered b0=1234, b1=ABCD, vr=0055, flag_fin asserted on the 0xF7 byte.
